// File: rtl/udma_tx_burst_arbiter_if.sv
// Request/grant bus between the TX channels and the TX burst arbiter.
// master drives requests and the ack strobe; slave (the arbiter) returns the grant.
interface udma_tx_burst_arbiter_if #(
  parameter int N_CH    = 16,
  parameter int BURST_W = 4
);
  localparam int S = $clog2(N_CH);

  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    hp_mask;
  logic [BURST_W-1:0] cfg_burst_len;
  logic               grant_ack;
  logic [N_CH-1:0]    grant;
  logic [S-1:0]       grant_idx;
  logic               any_grant;
  logic               locked;

  modport master (
    output req, hp_mask, cfg_burst_len, grant_ack,
    input  grant, grant_idx, any_grant, locked
  );

  modport slave (
    input  req, hp_mask, cfg_burst_len, grant_ack,
    output grant, grant_idx, any_grant, locked
  );
endinterface

// File: rtl/udma_tx_burst_arbiter.sv
// TX read-path scheduler: two-level priority round-robin with burst locking.
// Optional per-channel ack statistics when UDMA_TX_ARB_STATS_EN is defined.
//
// state   | meaning
// ST_ARB  | round-robin arbitration among the (high-priority if any) requesters
// ST_LOCK | grant held on lock_ch until burst length reached or its request drops
module udma_tx_burst_arbiter #(
  parameter int N_CH    = 16,
  parameter int BURST_W = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  udma_tx_burst_arbiter_if.slave  bus
`ifdef UDMA_TX_ARB_STATS_EN
  ,
  input  logic                    stats_clr_i,
  output logic [N_CH-1:0][15:0]   ack_cnt_o
`endif
);
  localparam int S = $clog2(N_CH);
  localparam logic [S:0] N_CH_W = (S+1)'(N_CH);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t             st_q, st_d;
  logic [S-1:0]       rr_ptr_q, rr_ptr_d;
  logic [S-1:0]       lock_ch_q, lock_ch_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [N_CH-1:0]    cand;
  logic [S:0]         pos;
  logic [S-1:0]       win_idx;
  logic               win_vld;
  logic               grant_vld;
  logic [S-1:0]       gnt_idx;
  logic [N_CH-1:0]    grant_vec;
  logic [BURST_W:0]   cnt_inc;

  // Rotating scan from rr_ptr; pos stays below 2*N_CH so one subtract wraps it.
  always_comb begin
    cand    = ((bus.req & bus.hp_mask) != '0) ? (bus.req & bus.hp_mask) : bus.req;
    win_idx = '0;
    win_vld = 1'b0;
    pos     = '0;
    for (int k = 0; k < N_CH; k++) begin
      pos = {1'b0, rr_ptr_q} + (S+1)'(k);
      if (pos >= N_CH_W) pos = pos - N_CH_W;
      if (!win_vld && cand[pos[S-1:0]]) begin
        win_vld = 1'b1;
        win_idx = pos[S-1:0];
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    gnt_idx   = '0;
    if (!rst_i) begin
      if (st_q == ST_LOCK) begin
        grant_vld = bus.req[lock_ch_q];
        gnt_idx   = lock_ch_q;
      end else begin
        grant_vld = win_vld;
        gnt_idx   = win_idx;
      end
    end
  end

  assign grant_vec     = grant_vld ? ({{(N_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign bus.grant     = grant_vec;
  assign bus.grant_idx = grant_vld ? gnt_idx : '0;
  assign bus.any_grant = grant_vld;
  assign bus.locked    = (st_q == ST_LOCK);

  always_comb begin
    st_d        = st_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    burst_cnt_d = burst_cnt_q;
    cnt_inc     = {1'b0, burst_cnt_q} + 1'b1;
    if (st_q == ST_ARB) begin
      if (bus.grant_ack && grant_vld) begin
        rr_ptr_d = (win_idx == S'(N_CH-1)) ? '0 : win_idx + 1'b1;
        if (bus.cfg_burst_len >= BURST_W'(2)) begin
          st_d        = ST_LOCK;
          lock_ch_d   = win_idx;
          burst_cnt_d = BURST_W'(1);
        end
      end
    end else begin
      if (!bus.req[lock_ch_q]) begin
        st_d        = ST_ARB;
        burst_cnt_d = '0;
      end else if (bus.grant_ack) begin
        // Length is compared live, so a shrunk or zero value releases on this ack.
        if (cnt_inc >= {1'b0, bus.cfg_burst_len}) begin
          st_d        = ST_ARB;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_inc[BURST_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q        <= ST_ARB;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef UDMA_TX_ARB_STATS_EN
  logic [N_CH-1:0][15:0] ack_cnt_q, ack_cnt_d;

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (stats_clr_i) begin
        ack_cnt_d[i] = '0;
      end else if (bus.grant_ack && grant_vec[i] && (ack_cnt_q[i] != 16'hFFFF)) begin
        ack_cnt_d[i] = ack_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ack_cnt_q <= '0;
    else       ack_cnt_q <= ack_cnt_d;
  end

  assign ack_cnt_o = ack_cnt_q;
`endif
endmodule

// File: tb/tb_udma_tx_burst_arbiter.sv
// Scoreboard bench for udma_tx_burst_arbiter: directed plan sequences plus random traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_udma_tx_burst_arbiter;
  localparam int N = 16;
  localparam int BW = 4;

  typedef struct {
    bit any;
    int idx;
    bit lck;
  } exp_t;

  logic clk;
  logic rst;
  udma_tx_burst_arbiter_if #(.N_CH(N), .BURST_W(BW)) bus();
`ifdef UDMA_TX_ARB_STATS_EN
  logic              stats_clr;
  logic [N-1:0][15:0] ack_cnt;
  bit                clr_req;
  int                m_cnt [N];
`endif

  udma_tx_burst_arbiter #(.N_CH(N), .BURST_W(BW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef UDMA_TX_ARB_STATS_EN
    ,
    .stats_clr_i (stats_clr),
    .ack_cnt_o   (ack_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t me;

  // reference model state
  bit m_locked;
  int m_lock_ch;
  int m_done;
  int m_next;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic exp_t model_out(logic [N-1:0] r, logic [N-1:0] h);
    exp_t e;
    logic [N-1:0] pool;
    e.any = 0; e.idx = 0; e.lck = m_locked;
    if (m_locked) begin
      if (r[m_lock_ch]) begin e.any = 1; e.idx = m_lock_ch; end
    end else begin
      pool = ((r & h) != 0) ? (r & h) : r;
      for (int off = 0; off < N; off++) begin
        if (!e.any && pool[(m_next + off) % N]) begin
          e.any = 1;
          e.idx = (m_next + off) % N;
        end
      end
    end
    return e;
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_lock_ch = 0; m_done = 0; m_next = 0;
`ifdef UDMA_TX_ARB_STATS_EN
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
  endfunction

  function automatic void model_update(logic [N-1:0] r, int c, bit a, exp_t g);
`ifdef UDMA_TX_ARB_STATS_EN
    if (clr_req) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (a && g.any && m_cnt[g.idx] < 65535) begin
      m_cnt[g.idx]++;
    end
`endif
    if (m_locked) begin
      if (!r[m_lock_ch]) begin
        m_locked = 0; m_done = 0;
      end else if (a) begin
        m_done++;
        if (m_done >= c) begin m_locked = 0; m_done = 0; end
      end
    end else if (a && g.any) begin
      m_next = (g.idx + 1) % N;
      if (c >= 2) begin m_locked = 1; m_lock_ch = g.idx; m_done = 1; end
    end
  endfunction

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] h, input int c, input bit a,
                      input bit use_exp = 0, input bit e_any = 0, input int e_idx = 0,
                      input bit e_lck = 0);
    exp_t e;
    exp_t g;
    @(posedge clk); #1;
    rst               = 1'b0;
    bus.req           = r;
    bus.hp_mask       = h;
    bus.cfg_burst_len = BW'(c);
    bus.grant_ack     = a;
`ifdef UDMA_TX_ARB_STATS_EN
    stats_clr = clr_req;
`endif
    g = model_out(r, h);
    e = g;
    if (use_exp) begin e.any = e_any; e.idx = e_idx; e.lck = e_lck; end
    q.push_back(e);
    model_update(r, c, a, g);
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req = r;
    bus.grant_ack = 1'b1;
    e.any = 0; e.idx = 0; e.lck = 0;
    q.push_back(e);
    model_reset();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("any_grant", 32'(bus.any_grant), 32'(me.any));
      chk("grant_idx", 32'(bus.grant_idx), 32'(me.idx));
      chk("grant_onehot", 32'(bus.grant), me.any ? (32'd1 << me.idx) : 32'd0);
      chk("locked", 32'(bus.locked), 32'(me.lck));
    end
  end

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.hp_mask = '0; bus.cfg_burst_len = '0; bus.grant_ack = 1'b0;
`ifdef UDMA_TX_ARB_STATS_EN
    stats_clr = 1'b0;
    clr_req = 0;
`endif
    model_reset();
    do_reset(16'hFFFF);
    do_reset(16'h0000);

    // round robin, no lock
    step(16'h0111, 0, 1, 1, 1, 1, 0, 0);
    step(16'h0111, 0, 1, 1, 1, 1, 4, 0);
    step(16'h0111, 0, 1, 1, 1, 1, 8, 0);
    step(16'h0111, 0, 1, 1, 1, 1, 0, 0);
    step(16'h0111, 0, 1, 1, 1, 1, 4, 0);
    // wrap-around
    step(16'h4000, 0, 1, 1, 1, 1, 14, 0);
    step(16'h8001, 0, 1, 1, 1, 1, 15, 0);
    step(16'h8001, 0, 1, 1, 1, 1, 0, 0);
    // burst lock of 3
    step(16'h0006, 0, 3, 1, 1, 1, 1, 0);
    step(16'h0006, 0, 3, 1, 1, 1, 1, 1);
    step(16'h0006, 0, 3, 1, 1, 1, 1, 1);
    step(16'h0006, 0, 3, 1, 1, 1, 2, 0);
    step(16'h0006, 0, 3, 1, 1, 1, 2, 1);
    step(16'h0006, 0, 3, 1, 1, 1, 2, 1);
    // high priority does not preempt lock
    step(16'h0004, 0, 4, 1, 1, 1, 2, 0);
    step(16'h0024, 16'h0020, 4, 1, 1, 1, 2, 1);
    step(16'h0024, 16'h0020, 4, 1, 1, 1, 2, 1);
    step(16'h0024, 16'h0020, 4, 1, 1, 1, 2, 1);
    step(16'h0024, 16'h0020, 4, 0, 1, 1, 5, 0);
    step(16'h0024, 16'h0020, 1, 1, 1, 1, 5, 0);
    // lock drop bubble, ack during bubble ignored
    step(16'h0008, 0, 4, 1, 1, 1, 3, 0);
    step(16'h0030, 0, 4, 1, 1, 0, 0, 1);
    step(16'h0030, 0, 1, 1, 1, 1, 4, 0);
    // reset mid-lock
    step(16'h0080, 0, 4, 1, 1, 1, 7, 0);
    step(16'h0080, 0, 4, 0, 1, 1, 7, 1);
    do_reset(16'h0081);
    step(16'h0081, 0, 1, 0, 1, 1, 0, 0);
    // burst length shrunk mid-lock
    step(16'h0200, 0, 5, 1, 1, 1, 9, 0);
    step(16'h0200, 0, 5, 1, 1, 1, 9, 1);
    step(16'h0200, 0, 2, 1, 1, 1, 9, 1);
    step(16'h0200, 0, 2, 0, 1, 1, 9, 0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] r;
      logic [N-1:0] h;
      r = N'($urandom) & N'($urandom);
      h = N'($urandom) & N'($urandom) & N'($urandom);
`ifdef UDMA_TX_ARB_STATS_EN
      clr_req = ($urandom_range(0, 99) == 0);
`endif
      if ($urandom_range(0, 199) == 0) do_reset(r);
      else step(r, h, int'($urandom_range(0, 5)), ($urandom_range(0, 9) < 7));
    end
`ifdef UDMA_TX_ARB_STATS_EN
    clr_req = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < N; i++) chk("ack_cnt_rand", 32'(ack_cnt[i]), 32'(m_cnt[i]));
    for (int n = 0; n < 70000; n++) step(16'h0001, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("ack_cnt_sat", 32'(ack_cnt[0]), 32'hFFFF);
    step(16'h0001, 0, 1, 1);
    clr_req = 1;
    step(16'h0001, 0, 1, 1);
    clr_req = 0;
    step(0, 0, 1, 0);
    chk("ack_cnt_clr", 32'(ack_cnt[0]), 32'h0);
`endif
    step(0, 0, 1, 0);

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udma_tx_burst_arbiter.md
Name: udma_tx_burst_arbiter

Overview:
- Scheduler for the shared TX read path. Picks one of N_CH requesting channels (linear and external) for each slot of the internal request FIFO.
- Replaces the plain round-robin arbiter with two additions: a strict two-level priority (high-priority mask) and burst locking, which holds the grant on one channel for up to cfg_burst_len_i consecutive acknowledged transfers.
- Sits between the channel request vector and the TX FIFO write port. grant_ack_i is the FIFO-ready / sample strobe.

Parameters:
- N_CH, 16, number of requesters; must be >= 2.
- BURST_W, 4, width of the burst-length configuration.
- (local) S = $clog2(N_CH), index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_i  in  N_CH  per-channel request, level, held until granted.
- hp_mask_i  in  N_CH  1 = channel in the high-priority class.
- cfg_burst_len_i  in  BURST_W  maximum consecutive acks per lock; 0 or 1 = no locking.
- grant_ack_i  in  1  the current grant is consumed this cycle.
- grant_o  out  N_CH  one-hot grant (combinational), 0 when none.
- grant_idx_o  out  S  binary index of grant_o, 0 when none.
- any_grant_o  out  1  OR of grant_o.
- locked_o  out  1  registered; state is LOCK.

Behaviour:
- State: st (ARB/LOCK), rr_ptr[S], lock_ch[S], burst_cnt[BURST_W].
- Reset: st=ARB, rr_ptr=0, lock_ch=0, burst_cnt=0. While rst_i=1, all outputs are 0.
- ARB grant: if (req_i & hp_mask_i) != 0, the candidate set is the high-priority requesters; otherwise it is all of req_i.
  - Winner = first candidate scanning upward from rr_ptr, with modulo-N_CH wrap-around.
  - Combinational, zero-cycle latency from req_i.
- ARB on grant_ack_i & any_grant_o:
  - rr_ptr <= winner+1 (wraps N_CH-1 -> 0).
  - If cfg_burst_len_i >= 2: st <= LOCK, lock_ch <= winner, burst_cnt <= 1. Otherwise stay in ARB.
- LOCK grant: grant_o = onehot(lock_ch) if req_i[lock_ch]=1. The priority mask is ignored while locked.
  - If req_i[lock_ch]=0: grant_o=0 this cycle (one-cycle bubble), st <= ARB, burst_cnt <= 0.
- LOCK on grant_ack_i with grant valid:
  - burst_cnt+1 >= cfg_burst_len_i: st <= ARB, burst_cnt <= 0.
  - Otherwise burst_cnt <= burst_cnt+1.
  - rr_ptr is not changed in LOCK.
- cfg_burst_len_i changed mid-lock: the new value is used at the next ack. If burst_cnt is already >= the new value, the lock releases on that ack. A value of 0 mid-lock also releases on the next ack.
- A high-priority request arriving during a lock does not preempt it; it wins at the first ARB cycle.
- grant_ack_i with any_grant_o=0: ignored, no state change.
- The grant is stable while grant_ack_i=0 and req_i/hp_mask_i are unchanged. req_i is not required to be stable after ack.
- Asserting rst_i mid-lock: immediate return to the reset state; no pending lock survives.
- grant_o is always one-hot or zero. grant_idx_o is consistent with grant_o in the same cycle.

Optional Feature:
- Macro: UDMA_TX_ARB_STATS_EN.
- Defined: adds input stats_clr_i (1) and output ack_cnt_o (N_CH x 16).
  - ack_cnt_o[i] increments on each grant_ack_i while grant_o[i]=1, saturating at 16'hFFFF.
  - stats_clr_i zeroes all counters synchronously and takes precedence over a same-cycle increment.
  - Counters reset to 0.
- Undefined: the stats ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Round-robin with no lock: N_CH=16, cfg_burst_len_i=1, req_i=16'h0111, grant_ack_i=1 every cycle -> grant_idx_o sequence 0,4,8,0,4; locked_o stays 0.
- Wrap-around: rr_ptr reaches 15 (after granting 14), req_i=16'h8001, ack each cycle -> grants 15 then 0.
- Burst lock: cfg_burst_len_i=3, req_i=16'h0006, ack each cycle -> grants 1,1,1,2,2,2; locked_o=1 from the cycle after the first ack until the third ack of each burst.
- Priority vs lock: lock on ch 2 (burst 4, count 1), hp_mask_i=16'h0020 and req_i[5] rises -> ch 2 is granted for 3 more acks, then ch 5.
- Lock drop: in LOCK on ch 3 with count 1, req_i[3] falls -> grant_o=0 for one cycle, then ARB grants the next requester scanning upward from rr_ptr (4 or later).
- Reset mid-lock: rst_i pulses while locked on ch 7 -> outputs 0 during reset; after release with req_i=16'h0081, the grant goes to ch 0 (rr_ptr=0). With UDMA_TX_ARB_STATS_EN: 70000 acks on ch 0 -> ack_cnt_o[0]=16'hFFFF; stats_clr_i -> 0.
